// File: rtl/tc_rate_meter_pkg.sv
// Shared state encodings and default widths for the tc rate meter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tc_rate_meter_pkg;

    localparam int WIN_W_DEF = 16;
    localparam int CNT_W_DEF = 8;
    localparam int D_W_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/tc_rate_meter_edge_detect_rise.sv
// Registered rising-edge detector: rise = din & ~din delayed one cycle.
// Latency: combinational from din against the previous cycle's sample.
// Backpressure: none.
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) din_q <= 1'b0;
        else     din_q <= din;
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/tc_rate_meter.sv
// Counts tc rising edges over a programmed window and reports rate + d snapshot.
// Latency: start sampled at edge T, result valid after edge T+window.
// Backpressure: result held in HOLD until ready; start ignored outside IDLE.
module tc_rate_meter
    import tc_rate_meter_pkg::*;
#(
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int D_W   = D_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] window,
    input  logic             tc,
    input  logic [D_W-1:0]   d,
    input  logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [CNT_W-1:0] rate,
    output logic [D_W-1:0]   d_snap,
    output logic             ovf
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_nxt;
    logic [WIN_W-1:0] timer;
    logic [CNT_W-1:0] acc, acc_nxt;
    logic             acc_sat;
    logic             tc_rise;
    logic             last;
    logic             go;

    edge_detect_rise u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (tc),
        .rise (tc_rise)
    );

    assign go   = start && (window != '0);
    assign last = (timer == WIN_W'(1));

    // An edge arriving while the accumulator is full is the one that overflows.
    always_comb begin
        acc_sat = (acc == CNT_MAX) && tc_rise;
        acc_nxt = acc_sat ? acc : acc + CNT_W'(tc_rise);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (go)    state_nxt = ST_MEAS;
            ST_MEAS: if (last)  state_nxt = ST_HOLD;
            ST_HOLD: if (ready) state_nxt = ST_IDLE;
            default:            state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer  <= '0;
            acc    <= '0;
            rate   <= '0;
            d_snap <= '0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go) begin
                        timer <= window;
                        acc   <= '0;
                        ovf   <= 1'b0;
                    end
                end
                ST_MEAS: begin
                    timer <= timer - WIN_W'(1);
                    acc   <= acc_nxt;
                    if (acc_sat) ovf <= 1'b1;
                    if (last) begin
                        rate   <= acc_nxt;
                        d_snap <= d;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == ST_MEAS);
    assign valid = (state == ST_HOLD);

endmodule

// File: tb/tb_tc_rate_meter.sv
// Directed bench for tc_rate_meter: table of measurement windows plus hand-written
// sequences for hold/backpressure, window=0 and mid-measurement reset.
module tb_tc_rate_meter;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] window;
    logic        tc;
    logic [3:0]  d;
    logic        ready;
    logic        busy;
    logic        valid;
    logic [7:0]  rate;
    logic [3:0]  d_snap;
    logic        ovf;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    tc_rate_meter #(.WIN_W(16), .CNT_W(8), .D_W(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .window (window),
        .tc     (tc),
        .d      (d),
        .ready  (ready),
        .busy   (busy),
        .valid  (valid),
        .rate   (rate),
        .d_snap (d_snap),
        .ovf    (ovf)
    );

    // mode: 0 tc low, 1 tc held high from before start, 2 toggle (rise on odd cycles),
    //       3 high for cycles [a, a+b), 4 counter b=10 l=13 (tc when count==13)
    typedef struct {
        int win;
        int mode;
        int a;
        int b;
        int exp_rate;
        int exp_ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_meas(input vec_t v, input string nm, input bit do_ack);
        int dexp;
        int cnt;
        cnt   = 10;
        tc    = (v.mode == 1);
        d     = (v.mode == 4) ? 4'(cnt) : 4'd5;
        tick();
        start  = 1'b1;
        window = 16'(v.win);
        tick();
        start = 1'b0;
        chk({nm, ".busy_start"}, busy, 1);
        chk({nm, ".ovf_clr"}, ovf, 0);
        dexp = 0;
        for (int k = 1; k <= v.win; k++) begin
            case (v.mode)
                0: tc = 1'b0;
                1: tc = 1'b1;
                2: tc = k[0];
                3: tc = (k >= v.a) && (k < v.a + v.b);
                default: begin
                    cnt = (cnt == 13) ? 10 : cnt + 1;
                    tc  = (cnt == 13);
                end
            endcase
            d    = (v.mode == 4) ? 4'(cnt) : 4'(k * 3 + 1);
            dexp = int'(d);
            if (k == v.win) chk({nm, ".valid_early"}, valid, 0);
            tick();
        end
        chk({nm, ".valid"}, valid, 1);
        chk({nm, ".busy_end"}, busy, 0);
        chk({nm, ".rate"}, rate, v.exp_rate);
        chk({nm, ".ovf"}, ovf, v.exp_ovf);
        chk({nm, ".d_snap"}, d_snap, dexp);
        tc = 1'b0;
        if (do_ack) begin
            ready = 1'b1;
            tick();
            ready = 1'b0;
            chk({nm, ".valid_ack"}, valid, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int bad;
        vecs[0] = '{40, 4, 0, 0, 10, 0};
        vecs[1] = '{10, 3, 4, 3, 1, 0};
        vecs[2] = '{8, 1, 0, 0, 0, 0};
        vecs[3] = '{600, 2, 0, 0, 255, 1};
        vecs[4] = '{510, 2, 0, 0, 255, 0};
        vecs[5] = '{512, 2, 0, 0, 255, 1};
        vecs[6] = '{1, 3, 1, 1, 1, 0};
        vecs[7] = '{10, 2, 0, 0, 5, 0};
        vecs[8] = '{6, 0, 0, 0, 0, 0};

        rst = 1'b1; start = 1'b0; window = '0; tc = 1'b0; d = '0; ready = 1'b0;
        #1;
        chk("rst.busy", busy, 0);
        chk("rst.valid", valid, 0);
        chk("rst.rate", rate, 0);
        chk("rst.d_snap", d_snap, 0);
        chk("rst.ovf", ovf, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_meas(vecs[i], $sformatf("vec%0d", i), 1'b1);
            tick();
        end

        // Result pending under backpressure; start must not launch a new window.
        run_meas(vecs[7], "hold", 1'b0);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            start  = (i == 3);
            window = 16'd20;
            tick();
            if (valid !== 1'b1 || busy !== 1'b0 || rate !== 8'd5) bad++;
        end
        start = 1'b0;
        chk("hold.stable", bad, 0);
        ready = 1'b1;
        start = 1'b1;
        tick();
        ready = 1'b0;
        start = 1'b0;
        chk("hold.valid_drop", valid, 0);
        chk("hold.no_start", busy, 0);
        tick();
        chk("hold.idle", busy, 0);

        // window=0 is ignored
        start  = 1'b1;
        window = 16'd0;
        tick();
        start = 1'b0;
        chk("win0.busy", busy, 0);
        tick();
        chk("win0.valid", valid, 0);

        // Reset in the middle of a window discards it
        start  = 1'b1;
        window = 16'd50;
        tick();
        start = 1'b0;
        chk("mrst.busy", busy, 1);
        for (int k = 1; k <= 20; k++) begin
            tc = k[0];
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.busy0", busy, 0);
        chk("mrst.valid0", valid, 0);
        chk("mrst.rate0", rate, 0);
        chk("mrst.d_snap0", d_snap, 0);
        chk("mrst.ovf0", ovf, 0);
        tick();
        rst = 1'b0;
        bad = 0;
        for (int k = 0; k < 60; k++) begin
            tc = k[0];
            tick();
            if (valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("mrst.no_result", bad, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
